// File: rtl/process_conv_in.sv
// process_conv_in: fetches feature rows over the pread port and writes them, tagged with
// (channel-group, row), into the input buffer. Define CONV_IN_PAD_EN for per-frame zero-row padding.
module process_conv_in #(
    parameter int unsigned CG_SIZE = 16,
    parameter int unsigned FEAT_W  = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ROW_W   = 10,
    parameter int unsigned CG_W    = 6,
    parameter int unsigned SEQ_W   = 8,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [ADDR_W-1:0]         cmd_row_stride,
    input  logic [ADDR_W-1:0]         cmd_frame_size,
    input  logic [ROW_W-1:0]          cmd_rows1,
    input  logic [CG_W-1:0]           cmd_cg_max,
    input  logic [SEQ_W-1:0]          cmd_seq,
`ifdef CONV_IN_PAD_EN
    input  logic [1:0]                cmd_pad_top,
    input  logic [1:0]                cmd_pad_bot,
`endif
    output logic                      pread_req,
    output logic [ADDR_W-1:0]         pread_addr,
    input  logic                      pread_gnt,
    input  logic                      pread_rvalid,
    input  logic [CG_SIZE*FEAT_W-1:0] pread_rdata,
    output logic                      inbuf_we,
    input  logic                      inbuf_ready,
    output logic [CG_W-1:0]           inbuf_cg,
    output logic [ROW_W-1:0]          inbuf_row,
    output logic [CG_SIZE*FEAT_W-1:0] inbuf_data,
    output logic                      busy,
    output logic                      done,
    output logic [SEQ_W-1:0]          finished_seq
);
    localparam int unsigned DataW = CG_SIZE * FEAT_W;
    localparam int unsigned PtrW  = $clog2(MAX_OUT);
    localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
    localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUT);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] stride_q, stride_d, fsize_q, fsize_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, frame_start_q, frame_start_d;
    logic [ROW_W-1:0]  rows1_q, rows1_d, rd_row_q, rd_row_d, wr_row_q, wr_row_d;
    logic [CG_W-1:0]   cg_max_q, cg_max_d, rd_cg_q, rd_cg_d, wr_cg_q, wr_cg_d;
    logic [SEQ_W-1:0]  seq_q, seq_d, fin_seq_q, fin_seq_d;
    logic              done_q, done_d;
    logic [CntW-1:0]   outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]   fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
    logic [DataW-1:0]  fifo_mem_q [MAX_OUT];

    logic [ROW_W-1:0]  row_last;
    logic              rd_in_pad;

`ifdef CONV_IN_PAD_EN
    logic [1:0]        pad_top_q, pad_top_d, pad_bot_q, pad_bot_d;
    logic [ROW_W-1:0]  mem_first, mem_last;

    assign mem_first = ROW_W'(pad_top_q);
    assign mem_last  = mem_first + rows1_q;
    assign row_last  = mem_last + ROW_W'(pad_bot_q);
    assign rd_in_pad = (rd_row_q < mem_first) || (rd_row_q > mem_last);
`else
    assign row_last  = rows1_q;
    assign rd_in_pad = 1'b0;
`endif

    logic [CntW:0] credit_used;
    logic          credit_ok, fetching, rd_grant, pad_push, slot_adv;
    logic          rsp_push, fifo_push, fifo_pop;

    // Every read in flight and every buffered row holds one credit.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign credit_ok   = credit_used < {1'b0, MaxOut};
    assign fetching    = (state_q == StFetch);
    assign pread_req   = fetching && credit_ok && !rd_in_pad;
    assign pread_addr  = rd_addr_q;
    assign rd_grant    = pread_req && pread_gnt;
    // Zero rows wait for all reads to return so they land in order.
    assign pad_push    = fetching && credit_ok && rd_in_pad && (outst_q == '0);
    assign slot_adv    = rd_grant || pad_push;
    assign rsp_push    = pread_rvalid && (outst_q != '0);
    assign fifo_push   = rsp_push || pad_push;
    assign inbuf_we    = (fifo_cnt_q != '0);
    assign fifo_pop    = inbuf_we && inbuf_ready;
    assign inbuf_data  = inbuf_we ? fifo_mem_q[fifo_rptr_q] : '0;
    assign inbuf_cg    = wr_cg_q;
    assign inbuf_row   = wr_row_q;
    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign finished_seq = fin_seq_q;

    always_comb begin
        outst_d     = outst_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        if (rd_grant && !rsp_push) begin
            outst_d = outst_q + 1'b1;
        end else if (!rd_grant && rsp_push) begin
            outst_d = outst_q - 1'b1;
        end
        if (fifo_push) fifo_wptr_d = fifo_wptr_q + 1'b1;
        if (fifo_pop)  fifo_rptr_d = fifo_rptr_q + 1'b1;
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        stride_d      = stride_q;
        fsize_d       = fsize_q;
        rows1_d       = rows1_q;
        cg_max_d      = cg_max_q;
        seq_d         = seq_q;
        rd_addr_d     = rd_addr_q;
        frame_start_d = frame_start_q;
        rd_row_d      = rd_row_q;
        rd_cg_d       = rd_cg_q;
        wr_row_d      = wr_row_q;
        wr_cg_d       = wr_cg_q;
        fin_seq_d     = fin_seq_q;
        done_d        = 1'b0;
`ifdef CONV_IN_PAD_EN
        pad_top_d     = pad_top_q;
        pad_bot_d     = pad_bot_q;
`endif

        if (fifo_pop) begin
            if (wr_row_q == row_last) begin
                wr_row_d = '0;
                wr_cg_d  = wr_cg_q + 1'b1;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d       = StFetch;
                    stride_d      = cmd_row_stride;
                    fsize_d       = cmd_frame_size;
                    rows1_d       = cmd_rows1;
                    cg_max_d      = cmd_cg_max;
                    seq_d         = cmd_seq;
                    rd_addr_d     = cmd_addr;
                    frame_start_d = cmd_addr;
                    rd_row_d      = '0;
                    rd_cg_d       = '0;
                    wr_row_d      = '0;
                    wr_cg_d       = '0;
`ifdef CONV_IN_PAD_EN
                    pad_top_d     = cmd_pad_top;
                    pad_bot_d     = cmd_pad_bot;
`endif
                end
            end
            StFetch: begin
                if (slot_adv) begin
                    if (rd_row_q == row_last) begin
                        frame_start_d = frame_start_q + fsize_q;
                        rd_addr_d     = frame_start_q + fsize_q;
                        rd_row_d      = '0;
                        rd_cg_d       = rd_cg_q + 1'b1;
                        if (rd_cg_q == cg_max_q) state_d = StDrain;
                    end else begin
                        rd_row_d = rd_row_q + 1'b1;
                        if (rd_grant) rd_addr_d = rd_addr_q + stride_q;
                    end
                end
            end
            StDrain: begin
                // Look at next-cycle counts so done follows the final write edge directly.
                if (outst_d == '0 && fifo_cnt_d == '0) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    fin_seq_d = seq_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            stride_q      <= '0;
            fsize_q       <= '0;
            rows1_q       <= '0;
            cg_max_q      <= '0;
            seq_q         <= '0;
            rd_addr_q     <= '0;
            frame_start_q <= '0;
            rd_row_q      <= '0;
            rd_cg_q       <= '0;
            wr_row_q      <= '0;
            wr_cg_q       <= '0;
            fin_seq_q     <= '0;
            done_q        <= 1'b0;
            outst_q       <= '0;
            fifo_cnt_q    <= '0;
            fifo_wptr_q   <= '0;
            fifo_rptr_q   <= '0;
`ifdef CONV_IN_PAD_EN
            pad_top_q     <= '0;
            pad_bot_q     <= '0;
`endif
        end else begin
            assert (!(fifo_push && !fifo_pop && fifo_cnt_q == MaxOut));
            state_q       <= state_d;
            stride_q      <= stride_d;
            fsize_q       <= fsize_d;
            rows1_q       <= rows1_d;
            cg_max_q      <= cg_max_d;
            seq_q         <= seq_d;
            rd_addr_q     <= rd_addr_d;
            frame_start_q <= frame_start_d;
            rd_row_q      <= rd_row_d;
            rd_cg_q       <= rd_cg_d;
            wr_row_q      <= wr_row_d;
            wr_cg_q       <= wr_cg_d;
            fin_seq_q     <= fin_seq_d;
            done_q        <= done_d;
            outst_q       <= outst_d;
            fifo_cnt_q    <= fifo_cnt_d;
            fifo_wptr_q   <= fifo_wptr_d;
            fifo_rptr_q   <= fifo_rptr_d;
`ifdef CONV_IN_PAD_EN
            pad_top_q     <= pad_top_d;
            pad_bot_q     <= pad_bot_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem_q[fifo_wptr_q] <= pad_push ? '0 : pread_rdata;
    end

endmodule

// File: tb/tb_process_conv_in.sv
// Self-checking bench for process_conv_in: randomized memory/buffer handshakes checked
// against a list-based model of the expected reads and tagged buffer writes.
module tb_process_conv_in;
    localparam int unsigned CG_SIZE = 16;
    localparam int unsigned FEAT_W  = 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ROW_W   = 10;
    localparam int unsigned CG_W    = 6;
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned DW      = CG_SIZE * FEAT_W;
`ifdef CONV_IN_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr, cmd_row_stride, cmd_frame_size;
    logic [ROW_W-1:0]  cmd_rows1;
    logic [CG_W-1:0]   cmd_cg_max;
    logic [SEQ_W-1:0]  cmd_seq;
`ifdef CONV_IN_PAD_EN
    logic [1:0]        cmd_pad_top, cmd_pad_bot;
`endif
    logic              pread_req, pread_gnt, pread_rvalid;
    logic [ADDR_W-1:0] pread_addr;
    logic [DW-1:0]     pread_rdata;
    logic              inbuf_we, inbuf_ready;
    logic [CG_W-1:0]   inbuf_cg;
    logic [ROW_W-1:0]  inbuf_row;
    logic [DW-1:0]     inbuf_data;
    logic              busy, done;
    logic [SEQ_W-1:0]  finished_seq;

    always #5 clock = ~clock;

    process_conv_in #(
        .CG_SIZE(CG_SIZE), .FEAT_W(FEAT_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
        .CG_W(CG_W), .SEQ_W(SEQ_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_row_stride(cmd_row_stride), .cmd_frame_size(cmd_frame_size),
        .cmd_rows1(cmd_rows1), .cmd_cg_max(cmd_cg_max), .cmd_seq(cmd_seq),
`ifdef CONV_IN_PAD_EN
        .cmd_pad_top(cmd_pad_top), .cmd_pad_bot(cmd_pad_bot),
`endif
        .pread_req(pread_req), .pread_addr(pread_addr), .pread_gnt(pread_gnt),
        .pread_rvalid(pread_rvalid), .pread_rdata(pread_rdata),
        .inbuf_we(inbuf_we), .inbuf_ready(inbuf_ready),
        .inbuf_cg(inbuf_cg), .inbuf_row(inbuf_row), .inbuf_data(inbuf_data),
        .busy(busy), .done(done), .finished_seq(finished_seq)
    );

    typedef struct {
        int            cg;
        int            row;
        logic [DW-1:0] data;
        bit            pad;
    } wr_t;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                rsp_due[$];
    logic [DW-1:0]     rsp_dat[$];

    int  cyc = 0, checks = 0, errors = 0;
    int  inflight, nreads, nwr, done_cnt, extra, last_wr, accept_cyc = -10;
    int  total_rd, total_wr;
    int  lat, gnt_pct, rdy_pct, stall_from, stall_to;
    bit  cmd_pending, rst_req, chk_first;
    logic [31:0]       salt;
    logic [SEQ_W-1:0]  seq_cur;
    logic [ADDR_W-1:0] c_addr, c_stride, c_fsize;
    int  c_rows1, c_cgmax, c_pt, c_pb;

    function automatic logic [DW-1:0] mem_data(input logic [31:0] a);
        return {a ^ salt, a + salt, ~a, salt ^ 32'h5a5a_0f0f};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected traffic straight from the frame/row layout, not from any incremental walk.
    task automatic build_expect();
        logic [31:0] a;
        wr_t w;
        total_rd = 0;
        total_wr = 0;
        for (int g = 0; g <= c_cgmax; g++) begin
            for (int s = 0; s <= c_pt + c_rows1 + c_pb; s++) begin
                w.cg  = g;
                w.row = s;
                if (s < c_pt || s > c_pt + c_rows1) begin
                    w.pad  = 1'b1;
                    w.data = '0;
                end else begin
                    a = c_addr + 32'(g) * c_fsize + 32'(s - c_pt) * c_stride;
                    w.pad  = 1'b0;
                    w.data = mem_data(a);
                    exp_rd.push_back(a);
                    total_rd++;
                end
                exp_wr.push_back(w);
                total_wr++;
            end
        end
    endtask

    task automatic tick();
        wr_t w;
        logic [ADDR_W-1:0] ea;
        @(negedge clock);
        cyc++;
        reset       = rst_req;
        cmd_valid   = cmd_pending;
        pread_gnt   = ($urandom_range(99) < gnt_pct);
        inbuf_ready = ($urandom_range(99) < rdy_pct) && !(cyc >= stall_from && cyc < stall_to);
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
            pread_rvalid = 1'b1;
            pread_rdata  = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
        end else begin
            pread_rvalid = 1'b0;
            pread_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (!reset) begin
            if (chk_first && cyc == accept_cyc + 1) check("req_after_cmd", pread_req, 1);
            if (cmd_valid && cmd_ready) begin
                cmd_pending = 1'b0;
                accept_cyc  = cyc;
                build_expect();
            end
            if (pread_req && pread_gnt) begin
                if (exp_rd.size() == 0) begin
                    extra++;
                end else begin
                    ea = exp_rd.pop_front();
                    check("pread_addr", pread_addr, ea);
                end
                rsp_due.push_back(cyc + lat);
                rsp_dat.push_back(mem_data(pread_addr));
                inflight++;
                nreads++;
            end
            if (inbuf_we && inbuf_ready) begin
                if (exp_wr.size() == 0) begin
                    extra++;
                end else begin
                    w = exp_wr.pop_front();
                    check("inbuf_cg", inbuf_cg, w.cg);
                    check("inbuf_row", inbuf_row, w.row);
                    check("inbuf_data", inbuf_data, w.data);
                    if (!w.pad) inflight--;
                end
                nwr++;
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_write", cyc, last_wr + 1);
                check("cmd_ready_at_done", cmd_ready, 1);
                check("busy_at_done", busy, 0);
                check("finished_seq", finished_seq, seq_cur);
            end
            check("credit_bound", inflight <= MAX_OUT, 1);
        end
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [31:0] stride,
                             input logic [31:0] fsize, input int rows1, input int cgmax,
                             input int seq, input int pt, input int pb, input int lat_i,
                             input int gpct, input int rpct);
        c_addr = addr; c_stride = stride; c_fsize = fsize;
        c_rows1 = rows1; c_cgmax = cgmax; c_pt = pt; c_pb = pb;
        lat = lat_i; gnt_pct = gpct; rdy_pct = rpct;
        salt = $urandom();
        seq_cur = SEQ_W'(seq);
        cmd_addr = addr; cmd_row_stride = stride; cmd_frame_size = fsize;
        cmd_rows1 = ROW_W'(rows1); cmd_cg_max = CG_W'(cgmax); cmd_seq = SEQ_W'(seq);
`ifdef CONV_IN_PAD_EN
        cmd_pad_top = 2'(pt); cmd_pad_bot = 2'(pb);
`endif
        done_cnt = 0; nreads = 0; nwr = 0; extra = 0; inflight = 0;
        cmd_pending = 1'b1;
    endtask

    task automatic finish_cmd(input int stall_len);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            tick();
            if (stall_len > 0 && cyc == stall_to - 1) begin
                check("req_drops_when_full", pread_req, 0);
                check("credits_all_used", inflight, MAX_OUT);
            end
        end
        for (int i = 0; i < 3; i++) tick();
        check("done_count", done_cnt, 1);
        check("read_count", nreads, total_rd);
        check("write_count", nwr, total_wr);
        check("unexpected_traffic", extra, 0);
        check("idle_after", busy, 0);
        stall_from = 0;
        stall_to   = 0;
        chk_first  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pread_req", pread_req, 0);
        check("rst_inbuf_we", inbuf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_finished_seq", finished_seq, 0);
        check("rst_pread_addr", pread_addr, 0);
        check("rst_inbuf_cg", inbuf_cg, 0);
        check("rst_inbuf_row", inbuf_row, 0);
        check("rst_inbuf_data", inbuf_data, 0);
    endtask

    initial begin
        int pt, pb;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_row_stride = '0; cmd_frame_size = '0;
        cmd_rows1 = '0; cmd_cg_max = '0; cmd_seq = '0;
`ifdef CONV_IN_PAD_EN
        cmd_pad_top = '0; cmd_pad_bot = '0;
`endif
        pread_gnt = 1'b0; pread_rvalid = 1'b0; pread_rdata = '0; inbuf_ready = 1'b0;
        gnt_pct = 100; rdy_pct = 100; lat = 1; stall_from = 0; stall_to = 0;
        salt = '0; seq_cur = '0; chk_first = 1'b0; cmd_pending = 1'b0;
        inflight = 0; nreads = 0; nwr = 0; done_cnt = 0; extra = 0; last_wr = -10;

        rst_req = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        rst_req = 1'b0;
        tick();
        check_reset_outputs();

        // Basic sequence
        chk_first = 1'b1;
        start_cmd(32'h100, 32'h10, 32'h80, 2, 1, 5, 0, 0, 1, 100, 100);
        finish_cmd(0);

        // Long memory latency: credits limit reads in flight
        start_cmd(32'h100, 32'h10, 32'h80, 2, 1, 6, 0, 0, 8, 100, 100);
        finish_cmd(0);

        // Buffer backpressure for 20 cycles shortly after the command
        start_cmd($urandom(), 32'h40, 32'h400, 3, 2, 7, 0, 0, 1, 100, 100);
        stall_from = cyc + 4;
        stall_to   = stall_from + 20;
        finish_cmd(20);

        // Reset with two reads outstanding; their responses arrive after reset
        start_cmd(32'h2000, 32'h20, 32'h200, 3, 1, 8, 0, 0, 8, 100, 100);
        for (int i = 0; i < 50 && nreads < 2; i++) tick();
        check("two_reads_before_reset", nreads, 2);
        rst_req = 1'b1;
        tick();
        tick();
        rst_req = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        inflight = 0;
        cmd_pending = 1'b0;
        tick();
        check_reset_outputs();
        for (int i = 0; i < 30 && rsp_due.size() > 0; i++) begin
            tick();
            check("stale_no_write", inbuf_we, 0);
            check("stale_not_busy", busy, 0);
        end
        check("stale_drained", rsp_due.size(), 0);
        tick();
        check("stale_no_done", done_cnt, 0);
        start_cmd(32'h3000, 32'h10, 32'h100, 1, 1, 9, 0, 0, 2, 100, 100);
        finish_cmd(0);

        // Address wrap
        start_cmd(32'hFFFF_FFF0, 32'h10, 32'h100, 1, 0, 10, 0, 0, 1, 100, 100);
        finish_cmd(0);

        // Randomized commands and handshakes
        for (int t = 0; t < 5; t++) begin
            pt = PadEn ? int'($urandom_range(3)) : 0;
            pb = PadEn ? int'($urandom_range(3)) : 0;
            start_cmd($urandom(), $urandom(), $urandom(), int'($urandom_range(5)),
                      int'($urandom_range(3)), 20 + t, pt, pb, int'($urandom_range(6, 1)),
                      int'($urandom_range(100, 40)), int'($urandom_range(100, 40)));
            finish_cmd(0);
        end

`ifdef CONV_IN_PAD_EN
        // Padding: two zero rows around two memory rows
        start_cmd(32'h500, 32'h10, 32'h100, 1, 0, 30, 1, 1, 1, 100, 100);
        finish_cmd(0);
        check("pad_reads", nreads, 2);
        check("pad_writes", nwr, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
